booth_seq_mult: RTL and testbench

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

---
 rtl/booth_seq_mult.sv | 127 ++++++++++++
 tb/tb_booth_seq_mult.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: signed M-bit a times signed N-bit b, two multiplier bits per cycle, M/2 cycles per product.
// Define BOOTH_ROUND_EN to get an N-bit rounded, saturated Q1.(M-1) result instead of the full N+M-bit product.
module booth_seq_mult #(
    parameter int N = 28,
    parameter int M = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef BOOTH_ROUND_EN
    output logic [N-1:0]   out_p,
`else
    output logic [N+M-1:0] out_p,
`endif
    output logic           busy
);

    localparam int W     = N + M;
    localparam int STEPS = M / 2;
    localparam int CW    = $clog2(STEPS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [M-1:0]  a_sh;
    logic          a_m1;
    logic [W-1:0]  mcand;
    logic [W-1:0]  acc;
    logic [W-1:0]  pp;
    logic [W-1:0]  acc_next;
    logic [CW-1:0] cnt;
    logic          last_step;

`ifdef BOOTH_ROUND_EN
    localparam logic [W:0] HALF = (W+1)'(1) << (M - 2);
    logic [W:0]   rnd_sum;
    logic [W:0]   rnd_sh;
    logic [N-1:0] res;
`else
    logic [W-1:0] res;
`endif

    // a_sh shifts right by two each step so the current triplet is always {a_sh[1:0], a_m1};
    // mcand shifts left by two so it is already the sign-extended b scaled by 4^i.
    always_comb begin
        pp = '0;
        case ({a_sh[1:0], a_m1})
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

    assign acc_next  = acc + pp;
    assign last_step = (cnt == CW'(STEPS - 1));

`ifdef BOOTH_ROUND_EN
    // One extra bit keeps the rounding add safe for the -2^(M-1) * -2^(N-1) corner.
    always_comb begin
        rnd_sum = {acc_next[W-1], acc_next} + HALF;
        rnd_sh  = $signed(rnd_sum) >>> (M - 1);
        if ((&rnd_sh[W:N-1]) || !(|rnd_sh[W:N-1]))
            res = rnd_sh[N-1:0];
        else if (rnd_sh[W])
            res = {1'b1, {(N-1){1'b0}}};
        else
            res = {1'b0, {(N-1){1'b1}}};
    end
`else
    assign res = acc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sh  <= '0;
            a_m1  <= 1'b0;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            out_p <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        a_m1  <= 1'b0;
                        mcand <= {{M{in_b[N-1]}}, in_b};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc   <= acc_next;
                    a_sh  <= a_sh >> 2;
                    a_m1  <= a_sh[1];
                    mcand <= mcand << 2;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        out_p <= res;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed-vector and random regression bench for booth_seq_mult (default N=28, M=16).
module tb_booth_seq_mult;
    localparam int N  = 28;
    localparam int M  = 16;
`ifdef BOOTH_ROUND_EN
    localparam int PW = N;
`else
    localparam int PW = N + M;
`endif
    localparam int NR = 400;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [M-1:0]  in_a = '0;
    logic signed [N-1:0]  in_b = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [PW-1:0]        out_p;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [M-1:0] a;
        logic signed [N-1:0] b;
        logic [PW-1:0]       p;
    } vec_t;
    vec_t vecs[$];
    logic [PW-1:0] exp_q[$];

    always #5 clk = ~clk;

    booth_seq_mult #(.N(N), .M(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic add(input logic signed [M-1:0] a, input logic signed [N-1:0] b, input logic [PW-1:0] p);
        vec_t v;
        v.a = a; v.b = b; v.p = p;
        vecs.push_back(v);
    endtask

    function automatic logic [PW-1:0] model(input logic signed [M-1:0] a, input logic signed [N-1:0] b);
        logic signed [N+M:0] p;
        p = a * b;
`ifdef BOOTH_ROUND_EN
        p = (p + 2**(M-2)) >>> (M-1);
        if (p > 2**(N-1) - 1)   p = 2**(N-1) - 1;
        if (p < -(2**(N-1)))    p = -(2**(N-1));
        return p[N-1:0];
`else
        return p[N+M-1:0];
`endif
    endfunction

    // Present one operand pair, wait for acceptance, then for out_valid; returns product and latency.
    task automatic run_op(input logic signed [M-1:0] a, input logic signed [N-1:0] b,
                          output logic [PW-1:0] p, output int lat);
        int w;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) fail("accept_timeout");
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 50);
        p = out_p;
    endtask

    initial begin
        logic [PW-1:0] p;
        logic [PW-1:0] e;
        int lat;
        int seen;
        int sent;
        int got;
        int cyc;
        logic acc_flag;
        logic signed [M-1:0] ra;
        logic signed [N-1:0] rb;

`ifdef BOOTH_ROUND_EN
        add(16'sd16384,  28'sd1000,        28'sd500);
        add(16'sd16384,  28'sd3,           28'sd2);
        add(-16'sd32768, -28'sd134217728,  28'sd134217727);
        add(-16'sd3,     28'sd7,           28'sd0);
        add(-16'sd32768, 28'sd134217727,   -28'sd134217727);
        add(-16'sd16384, 28'sd1000,        -28'sd500);
`else
        add(-16'sd3,     28'sd7,           -44'sd21);
        add(-16'sd32768, -28'sd134217728,  44'sd4398046511104);
        add(16'sd0,      28'sd12345,       44'sd0);
        add(16'sd0,      -28'sd134217728,  44'sd0);
        add(16'sd32767,  28'sd134217727,   44'sd4397912260609);
        add(-16'sd32768, 28'sd134217727,   -44'sd4398046478336);
        add(16'sd1,      -28'sd1,          -44'sd1);
        add(-16'sd1,     -28'sd1,          44'sd1);
        add(16'sd5,      -28'sd9,          -44'sd45);
        add(-16'sd32768, 28'sd1,           -44'sd32768);
`endif

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_p", out_p, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        // Directed table with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, p, lat);
            check($sformatf("vec%0d_p", i), p, vecs[i].p);
            check($sformatf("vec%0d_lat", i), lat, M/2);
            @(posedge clk);
            #1 check($sformatf("vec%0d_release", i), out_valid, 0);
        end

        // Backpressure: DONE holds for 5 cycles while in_valid pulses are ignored
        out_ready = 1'b0;
        e = model(16'sd6, -28'sd7);
        run_op(16'sd6, -28'sd7, p, lat);
        check("bp_p", p, e);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = M'(k + 1);
            in_b = 28'sd100;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_valid", k), out_valid, 1);
            check($sformatf("bp%0d_p", k), out_p, e);
            check($sformatf("bp%0d_in_ready", k), in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_exit_valid", out_valid, 0);
        check("bp_exit_in_ready", in_ready, 1);
        @(posedge clk);
        #1 check("bp_no_accept", busy, 0);

        // Reset during CALC step 3 aborts the operation
        @(negedge clk);
        in_a = 16'sd123; in_b = 28'sd456; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_p", out_p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("abort_in_ready", in_ready, 1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("abort_no_product", seen, 0);
        run_op(16'sd5, -28'sd9, p, lat);
        check("post_abort_p", p, model(16'sd5, -28'sd9));
        @(posedge clk);

        // Random regression with random in_valid gaps and out_ready stalls
        sent = 0; got = 0; cyc = 0; acc_flag = 1'b0;
        while ((sent < NR || got < sent) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (acc_flag) begin
                in_valid = 1'b0;
                acc_flag = 1'b0;
            end
            if (!in_valid && sent < NR && $urandom_range(0, 2) == 0) begin
                ra = M'($urandom);
                rb = N'($urandom);
                if ($urandom_range(0, 7) == 0) ra = {1'b1, {(M-1){1'b0}}};
                if ($urandom_range(0, 7) == 0) ra = {1'b0, {(M-1){1'b1}}};
                if ($urandom_range(0, 7) == 0) rb = {1'b1, {(N-1){1'b0}}};
                if ($urandom_range(0, 7) == 0) rb = {1'b0, {(N-1){1'b1}}};
                in_a = ra; in_b = rb; in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            acc_flag = in_valid && in_ready;
            if (acc_flag) begin
                exp_q.push_back(model(in_a, in_b));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail("rand_duplicate");
                else check($sformatf("rand%0d_p", got), out_p, exp_q.pop_front());
                got++;
            end
        end
        in_valid = 1'b0;
        check("rand_sent", sent, NR);
        check("rand_got", got, NR);
        check("rand_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
